// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {CPU_FIRST, HOST_FIRST} prio_t;

    typedef enum logic [1:0] {NONE, CPU, HOST} owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU port, host/debug port and memory-array signals of the arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus memory array side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and the
// host/debug port: one access per cycle, 1-cycle read data routed to its owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              do_halt,
    mem_port_arbiter_if.slave bus
);

    localparam int            BW          = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

    prio_t             prio_q, prio_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    owner_t            rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic cpu_gnt;
    logic host_gnt;
    logic host_masked;
    logic mem_we;

    // Grants are forced low while reset is asserted so nothing reaches the array.
    always_comb begin
        cpu_gnt     = 1'b0;
        host_gnt    = 1'b0;
        host_masked = (burst_cnt_q == BURST_LIMIT) && bus.cpu_req;
        if (!rst) begin
            cpu_gnt  = 1'b0;
            host_gnt = 1'b0;
        end else if (do_halt) begin
            host_gnt = bus.host_req;
        end else if (bus.cpu_req && bus.host_req && !host_masked) begin
            cpu_gnt  = (prio_q == CPU_FIRST);
            host_gnt = (prio_q == HOST_FIRST);
        end else begin
            cpu_gnt  = bus.cpu_req;
            host_gnt = bus.host_req && !host_masked;
        end
    end

    always_comb begin
        mem_we      = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (cpu_gnt) begin
            mem_we      = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
        end else if (host_gnt) begin
            mem_we      = bus.host_we;
            mem_addr_d  = bus.host_addr;
            mem_wdata_d = bus.host_wdata;
        end
    end

    // Fairness state is frozen while halted so contention resumes where it left off.
    always_comb begin
        prio_d      = prio_q;
        burst_cnt_d = burst_cnt_q;
        if (!do_halt) begin
            if (cpu_gnt) begin
                prio_d = HOST_FIRST;
            end else if (host_gnt && bus.cpu_req) begin
                prio_d = CPU_FIRST;
            end
            if (cpu_gnt || !bus.cpu_req) begin
                burst_cnt_d = '0;
            end else if (host_gnt) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rd_owner_d = NONE;
        if (cpu_gnt && !bus.cpu_we) begin
            rd_owner_d = CPU;
        end else if (host_gnt && !bus.host_we) begin
            rd_owner_d = HOST;
        end
        cpu_rdata_d  = (rd_owner_q == CPU)  ? bus.mem_rdata : cpu_rdata_q;
        host_rdata_d = (rd_owner_q == HOST) ? bus.mem_rdata : host_rdata_q;
    end

    // Clearing rd_owner drops any read in flight when reset hits.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            prio_q       <= CPU_FIRST;
            burst_cnt_q  <= '0;
            rd_owner_q   <= NONE;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            prio_q       <= prio_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_owner_q   <= rd_owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.host_gnt    = host_gnt;
    assign bus.cpu_stall   = rst && bus.cpu_req && !cpu_gnt;
    assign bus.cpu_rvalid  = (rd_owner_q == CPU);
    assign bus.host_rvalid = (rd_owner_q == HOST);
    assign bus.cpu_rdata   = cpu_rdata_d;
    assign bus.host_rdata  = host_rdata_d;

    assign bus.mem_en    = cpu_gnt | host_gnt;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr_d;
    assign bus.mem_wdata = mem_wdata_d;

    a_one_grant: assert property (@(posedge CLK) disable iff (!rst) !(cpu_gnt && host_gnt));
    a_halt_no_cpu: assert property (@(posedge CLK) disable iff (!rst) do_halt |-> !cpu_gnt);
    a_burst_bound: assert property (@(posedge CLK) disable iff (!rst) burst_cnt_q <= BURST_LIMIT);

endmodule
